lsu_request_queue: RTL and testbench
====================================

Name: lsu_request_queue

Overview:
- CPU-side load/store front end sitting directly upstream of the memory interface: buffers CPU memory requests in a small FIFO and issues them one at a time.
- Issues onto the memory interface's load/store/address/data/word_type/is_signed inputs and tracks busy/output_valid/write_ready to detect completion.
- Returns each result to the CPU through a valid/ready response channel, strictly in order.

Parameters:
DEPTH, 4, request FIFO entries; power of two, 2..16
TIMEOUT, 64, watchdog limit in cycles; used only with LSQ_TIMEOUT_EN

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
cpu_req_valid  in  1  request offered
cpu_req_ready  out  1  FIFO can accept; equals !full
cpu_req_is_store  in  1  1=store, 0=load
cpu_req_addr  in  13  byte address; bit0 = byte within 16-bit memory word
cpu_req_wdata  in  32  store data
cpu_req_word_type  in  2  00 byte, 01 halfword, 10 word, 11 illegal
cpu_req_signed  in  1  sign-extend load result
cpu_resp_valid  out  1  response available
cpu_resp_ready  in  1  CPU takes response
cpu_resp_data  out  32  load data; 0 for stores and errors
cpu_resp_is_store  out  1  response belongs to a store
cpu_resp_err  out  1  illegal word_type or timeout
mi_address  out  13  to memory interface address
mi_data_in  out  32  to memory interface data_in
mi_load  out  1  one-cycle load strobe
mi_store  out  1  one-cycle store strobe
mi_is_signed  out  1  to memory interface is_signed
mi_word_type  out  2  to memory interface word_type
mi_data_out  in  32  load result
mi_output_valid  in  1  load complete
mi_write_ready  in  1  store complete
mi_busy  in  1  memory interface occupied

Behaviour:
- Reset, async: FIFO empty, pointers/count 0, FSM IDLE. All outputs 0 except cpu_req_ready=1. Reset mid-transaction abandons the transaction; no response is produced.
- FIFO:
  - Enqueue when cpu_req_valid && cpu_req_ready. Entry = {is_store, addr, wdata, word_type, signed}.
  - Pointers wrap modulo DEPTH; count has log2(DEPTH)+1 bits.
  - Enqueue and dequeue in the same cycle leave count unchanged.
  - When full, cpu_req_ready=0 even if a dequeue happens that cycle; ready is derived from the registered count.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: FIFO non-empty and !mi_busy -> ISSUE. A request enqueued in cycle N is issued no earlier than N+1.
  - ISSUE, exactly one cycle:
    - Pop the head into the issue register.
    - If word_type=11: no strobe, go to RESP with err=1 and data=0.
    - Otherwise assert mi_load (or mi_store) for this cycle only, then go to WAIT.
    - mi_address, mi_data_in, mi_word_type and mi_is_signed are driven from the issue register from ISSUE until leaving WAIT, and held stable throughout.
  - WAIT:
    - Load: completes on mi_output_valid. Capture mi_data_out in the same cycle, go to RESP.
    - Store: completes on mi_write_ready, go to RESP with data=0.
    - The completion flag of the other type is ignored.
  - RESP:
    - cpu_resp_valid=1, and response fields are held stable until cpu_resp_ready.
    - On handshake: go to ISSUE if FIFO non-empty and !mi_busy, else go to IDLE.
    - Enqueues continue in every state.
- Minimum latency for a load: strobe at N+1; if completion arrives at cycle C, cpu_resp_valid is high at C+1.
- Strobes are never asserted while mi_busy=1 or while a transaction is outstanding.
- Responses are strictly in request order; there is no reordering or merging.

Optional Feature:
LSQ_TIMEOUT_EN
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without completion, go to RESP with err=1 and data=0.
  - Any late completion flags are ignored until the next ISSUE.
- Undefined: no counter; WAIT persists indefinitely; cpu_resp_err is set only for illegal word_type.

Test Plan:
- Single load: addr=0x004, word, unsigned; mi_output_valid at 3rd cycle after strobe with mi_data_out=0xDEADBEEF -> exactly one mi_load pulse with mi_address=0x004 held; cpu_resp_data=0xDEADBEEF, err=0, one cycle after completion.
- Fill FIFO: DEPTH=4, 5 back-to-back stores with mi_busy=1 -> cpu_req_ready=0 after the 4th; no mi_store while busy; after busy drops, 4 stores issue in order with matching mi_data_in; 5th accepted once space exists.
- Response backpressure: cpu_resp_ready=0 for 10 cycles -> resp fields stable, no new strobe; release -> next request issues.
- Illegal word_type=11 load -> no mi_load; cpu_resp_valid with err=1, data=0.
- Reset asserted during WAIT -> mi_* strobes 0 immediately, FIFO empty, cpu_resp_valid=0, cpu_req_ready=1; no stale response afterwards.
- LSQ_TIMEOUT_EN, TIMEOUT=8, load with no completion -> err=1 response after 8 WAIT cycles; a late mi_output_valid is ignored.

Source files
------------

// File: rtl/lsu_request_queue.sv
// lsu_request_queue: buffers CPU load/store requests in a DEPTH-entry FIFO,
// issues them one at a time to the memory interface and returns in-order
// responses over a valid/ready channel.
// Optional build macro LSQ_TIMEOUT_EN: adds a WAIT watchdog of TIMEOUT cycles
// that retires a stuck transaction with an error response.
module lsu_request_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic        cpu_req_is_store,
  input  logic [12:0] cpu_req_addr,
  input  logic [31:0] cpu_req_wdata,
  input  logic [1:0]  cpu_req_word_type,
  input  logic        cpu_req_signed,
  output logic        cpu_resp_valid,
  input  logic        cpu_resp_ready,
  output logic [31:0] cpu_resp_data,
  output logic        cpu_resp_is_store,
  output logic        cpu_resp_err,
  output logic [12:0] mi_address,
  output logic [31:0] mi_data_in,
  output logic        mi_load,
  output logic        mi_store,
  output logic        mi_is_signed,
  output logic [1:0]  mi_word_type,
  input  logic [31:0] mi_data_out,
  input  logic        mi_output_valid,
  input  logic        mi_write_ready,
  input  logic        mi_busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [1:0]  WT_ILLEGAL = 2'b11;

  typedef struct packed {
    logic        is_store;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [1:0]  word_type;
    logic        is_signed;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Elaboration-time parameter sanity
  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("lsu_request_queue: DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("lsu_request_queue: TIMEOUT must be at least 1");
  end

  req_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  state_t        state_q;
  req_t          issue_q;
  logic          load_q;
  logic          store_q;
  logic          resp_valid_q;
  logic [31:0]   resp_data_q;
  logic          resp_is_store_q;
  logic          resp_err_q;

`ifdef LSQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q;
`endif

  req_t req_in;
  req_t head;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  assign fifo_full     = (count_q == CW'(DEPTH));
  assign fifo_empty    = (count_q == '0);
  assign cpu_req_ready = !fifo_full;
  assign push          = cpu_req_valid && !fifo_full;
  assign head          = mem_q[rd_ptr_q];

  assign req_in.is_store  = cpu_req_is_store;
  assign req_in.addr      = cpu_req_addr;
  assign req_in.wdata     = cpu_req_wdata;
  assign req_in.word_type = cpu_req_word_type;
  assign req_in.is_signed = cpu_req_signed;

  // Pop the head whenever the FSM is free to start a new transaction
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty && !mi_busy) begin
      if (state_q == ST_IDLE) begin
        pop = 1'b1;
      end else if ((state_q == ST_RESP) && cpu_resp_ready) begin
        pop = 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= req_in;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Issue/complete/respond FSM with registered strobes and response fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      issue_q         <= '0;
      load_q          <= 1'b0;
      store_q         <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      resp_is_store_q <= 1'b0;
      resp_err_q      <= 1'b0;
`ifdef LSQ_TIMEOUT_EN
      timer_q         <= '0;
`endif
    end else begin
      load_q  <= 1'b0;
      store_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
        end
        ST_ISSUE: begin
          if (issue_q.word_type == WT_ILLEGAL) begin
            state_q         <= ST_RESP;
            resp_valid_q    <= 1'b1;
            resp_data_q     <= '0;
            resp_is_store_q <= issue_q.is_store;
            resp_err_q      <= 1'b1;
          end else begin
            state_q <= ST_WAIT;
`ifdef LSQ_TIMEOUT_EN
            timer_q <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (!issue_q.is_store && mi_output_valid) begin
            state_q         <= ST_RESP;
            resp_valid_q    <= 1'b1;
            resp_data_q     <= mi_data_out;
            resp_is_store_q <= 1'b0;
            resp_err_q      <= 1'b0;
          end else if (issue_q.is_store && mi_write_ready) begin
            state_q         <= ST_RESP;
            resp_valid_q    <= 1'b1;
            resp_data_q     <= '0;
            resp_is_store_q <= 1'b1;
            resp_err_q      <= 1'b0;
          end
`ifdef LSQ_TIMEOUT_EN
          else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_q         <= ST_RESP;
            resp_valid_q    <= 1'b1;
            resp_data_q     <= '0;
            resp_is_store_q <= issue_q.is_store;
            resp_err_q      <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
`endif
        end
        ST_RESP: begin
          if (cpu_resp_ready) begin
            state_q         <= ST_IDLE;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_is_store_q <= 1'b0;
            resp_err_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Start the next transaction; overrides the IDLE return above
      if (pop) begin
        state_q <= ST_ISSUE;
        issue_q <= head;
        load_q  <= (head.word_type != WT_ILLEGAL) && !head.is_store;
        store_q <= (head.word_type != WT_ILLEGAL) && head.is_store;
      end
    end
  end

  assign mi_address        = issue_q.addr;
  assign mi_data_in        = issue_q.wdata;
  assign mi_word_type      = issue_q.word_type;
  assign mi_is_signed      = issue_q.is_signed;
  assign mi_load           = load_q;
  assign mi_store          = store_q;
  assign cpu_resp_valid    = resp_valid_q;
  assign cpu_resp_data     = resp_data_q;
  assign cpu_resp_is_store = resp_is_store_q;
  assign cpu_resp_err      = resp_err_q;

endmodule

// File: tb/tb_lsu_request_queue.sv
// Directed self-checking bench for lsu_request_queue (DEPTH=4, TIMEOUT=8).
module tb_lsu_request_queue;

  logic        clk;
  logic        reset;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_req_is_store;
  logic [12:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic [1:0]  cpu_req_word_type;
  logic        cpu_req_signed;
  logic        cpu_resp_valid;
  logic        cpu_resp_ready;
  logic [31:0] cpu_resp_data;
  logic        cpu_resp_is_store;
  logic        cpu_resp_err;
  logic [12:0] mi_address;
  logic [31:0] mi_data_in;
  logic        mi_load;
  logic        mi_store;
  logic        mi_is_signed;
  logic [1:0]  mi_word_type;
  logic [31:0] mi_data_out;
  logic        mi_output_valid;
  logic        mi_write_ready;
  logic        mi_busy;

  int n_checks = 0;
  int n_fail   = 0;

  int load_cnt  = 0;
  int store_cnt = 0;
  int busy_viol = 0;
  logic [31:0] store_log [$];

  int          base_l, base_s, n, nresp, bad, accepted;
  logic        hs_req, hs_resp, seen;
  logic [31:0] cap_data;
  logic        cap_err, cap_st;

  lsu_request_queue #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .cpu_req_valid     (cpu_req_valid),
    .cpu_req_ready     (cpu_req_ready),
    .cpu_req_is_store  (cpu_req_is_store),
    .cpu_req_addr      (cpu_req_addr),
    .cpu_req_wdata     (cpu_req_wdata),
    .cpu_req_word_type (cpu_req_word_type),
    .cpu_req_signed    (cpu_req_signed),
    .cpu_resp_valid    (cpu_resp_valid),
    .cpu_resp_ready    (cpu_resp_ready),
    .cpu_resp_data     (cpu_resp_data),
    .cpu_resp_is_store (cpu_resp_is_store),
    .cpu_resp_err      (cpu_resp_err),
    .mi_address        (mi_address),
    .mi_data_in        (mi_data_in),
    .mi_load           (mi_load),
    .mi_store          (mi_store),
    .mi_is_signed      (mi_is_signed),
    .mi_word_type      (mi_word_type),
    .mi_data_out       (mi_data_out),
    .mi_output_valid   (mi_output_valid),
    .mi_write_ready    (mi_write_ready),
    .mi_busy           (mi_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor: counts pulses, logs store data, flags strobes under busy
  always @(negedge clk) begin
    if (mi_load) load_cnt++;
    if (mi_store) begin
      store_cnt++;
      store_log.push_back(mi_data_in);
    end
    if ((mi_load || mi_store) && mi_busy) busy_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic st, input logic [12:0] a, input logic [31:0] d,
                     input logic [1:0] wt, input logic sg);
    int k;
    cpu_req_valid     = 1'b1;
    cpu_req_is_store  = st;
    cpu_req_addr      = a;
    cpu_req_wdata     = d;
    cpu_req_word_type = wt;
    cpu_req_signed    = sg;
    k = 0;
    while (!cpu_req_ready && k < 50) begin
      tick();
      k++;
    end
    check("enq_ready", 32'(k < 50), 32'd1);
    tick();
    cpu_req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cpu_req_valid = 0; cpu_req_is_store = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
    cpu_req_word_type = '0; cpu_req_signed = 0; cpu_resp_ready = 0;
    mi_data_out = '0; mi_output_valid = 0; mi_write_ready = 0; mi_busy = 0;
    tick(); tick();
    check("rst_req_ready", 32'(cpu_req_ready), 32'd1);
    check("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    check("rst_strobes", 32'({mi_load, mi_store}), 32'd0);
    check("rst_addr", 32'(mi_address), 32'd0);
    reset = 1'b0;
    tick();

    // Single load with completion on the third cycle after the strobe
    base_l = load_cnt;
    enq(1'b0, 13'h004, 32'h0, 2'b10, 1'b0);
    tick();
    check("ld_strobe", 32'(mi_load), 32'd1);
    check("ld_addr", 32'(mi_address), 32'h004);
    check("ld_wt", 32'(mi_word_type), 32'd2);
    tick();
    check("ld_strobe_once", 32'(mi_load), 32'd0);
    mi_write_ready = 1'b1;
    tick();
    mi_write_ready = 1'b0;
    check("ld_ignore_wr", 32'(cpu_resp_valid), 32'd0);
    check("ld_addr_hold", 32'(mi_address), 32'h004);
    mi_output_valid = 1'b1;
    mi_data_out = 32'hDEADBEEF;
    tick();
    mi_output_valid = 1'b0;
    mi_data_out = '0;
    check("ld_resp_valid", 32'(cpu_resp_valid), 32'd1);
    check("ld_resp_data", cpu_resp_data, 32'hDEADBEEF);
    check("ld_resp_err", 32'(cpu_resp_err), 32'd0);
    check("ld_resp_st", 32'(cpu_resp_is_store), 32'd0);
    cpu_resp_ready = 1'b1;
    tick();
    cpu_resp_ready = 1'b0;
    check("ld_resp_done", 32'(cpu_resp_valid), 32'd0);
    check("ld_pulses", 32'(load_cnt - base_l), 32'd1);

    // Fill the FIFO while the memory interface is busy
    base_s = store_cnt;
    store_log.delete();
    mi_busy = 1'b1;
    for (int i = 0; i < 4; i++) enq(1'b1, 13'(13'h100 + 2 * i), 32'hA5A50000 + 32'(i), 2'b10, 1'b0);
    check("full_ready", 32'(cpu_req_ready), 32'd0);
    cpu_req_valid = 1'b1; cpu_req_is_store = 1'b1; cpu_req_addr = 13'h108;
    cpu_req_wdata = 32'hA5A50004; cpu_req_word_type = 2'b10; cpu_req_signed = 1'b0;
    tick(); tick(); tick();
    check("full_ready_hold", 32'(cpu_req_ready), 32'd0);
    check("busy_no_store", 32'(store_cnt - base_s), 32'd0);
    mi_busy = 1'b0; mi_write_ready = 1'b1; cpu_resp_ready = 1'b1;
    nresp = 0; bad = 0; accepted = 0;
    for (int c = 0; c < 200 && nresp < 5; c++) begin
      hs_req  = cpu_req_valid && cpu_req_ready;
      hs_resp = cpu_resp_valid;
      if (hs_resp && (cpu_resp_is_store !== 1'b1 || cpu_resp_err !== 1'b0 || cpu_resp_data !== 32'h0)) bad++;
      tick();
      if (hs_req) begin
        cpu_req_valid = 1'b0;
        accepted = 1;
      end
      if (hs_resp) nresp++;
    end
    mi_write_ready = 1'b0; cpu_resp_ready = 1'b0;
    check("fill_nresp", 32'(nresp), 32'd5);
    check("fill_fifth_acc", 32'(accepted), 32'd1);
    check("fill_resp_fields", 32'(bad), 32'd0);
    check("fill_nstores", 32'(store_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("fill_order%0d", i), (i < store_log.size()) ? store_log[i] : 32'hX,
            32'hA5A50000 + 32'(i));
    check("busy_viol", 32'(busy_viol), 32'd0);

    // Response backpressure with a store queued behind the load
    tick();
    base_s = store_cnt;
    enq(1'b0, 13'h020, 32'h0, 2'b01, 1'b1);
    tick();
    check("bp_ld_strobe", 32'(mi_load), 32'd1);
    check("bp_signed", 32'(mi_is_signed), 32'd1);
    check("bp_wt", 32'(mi_word_type), 32'd1);
    enq(1'b1, 13'h030, 32'hCAFEF00D, 2'b00, 1'b0);
    mi_output_valid = 1'b1;
    mi_data_out = 32'hFFFF8001;
    tick();
    mi_output_valid = 1'b0;
    check("bp_resp_valid", 32'(cpu_resp_valid), 32'd1);
    check("bp_resp_data", cpu_resp_data, 32'hFFFF8001);
    cap_data = cpu_resp_data; cap_err = cpu_resp_err; cap_st = cpu_resp_is_store;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (cpu_resp_valid !== 1'b1 || cpu_resp_data !== cap_data ||
          cpu_resp_err !== cap_err || cpu_resp_is_store !== cap_st) bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    check("bp_no_strobe", 32'(store_cnt - base_s), 32'd0);
    cpu_resp_ready = 1'b1;
    tick();
    cpu_resp_ready = 1'b0;
    check("bp_released", 32'(cpu_resp_valid), 32'd0);
    check("bp_st_strobe", 32'(mi_store), 32'd1);
    check("bp_st_data", mi_data_in, 32'hCAFEF00D);
    check("bp_st_addr", 32'(mi_address), 32'h030);
    tick();
    mi_write_ready = 1'b1;
    tick();
    mi_write_ready = 1'b0;
    check("bp_st_resp", 32'({cpu_resp_valid, cpu_resp_is_store, cpu_resp_err}), 32'b110);
    cpu_resp_ready = 1'b1;
    tick();
    cpu_resp_ready = 1'b0;

    // Illegal word type: no strobe, error response
    base_l = load_cnt;
    enq(1'b0, 13'h040, 32'h0, 2'b11, 1'b0);
    tick();
    check("ill_no_strobe", 32'(mi_load), 32'd0);
    tick();
    check("ill_resp_valid", 32'(cpu_resp_valid), 32'd1);
    check("ill_resp_err", 32'(cpu_resp_err), 32'd1);
    check("ill_resp_data", cpu_resp_data, 32'h0);
    check("ill_pulses", 32'(load_cnt - base_l), 32'd0);
    cpu_resp_ready = 1'b1;
    tick();
    cpu_resp_ready = 1'b0;

    // Reset during WAIT with a second request still queued
    enq(1'b0, 13'h060, 32'h0, 2'b10, 1'b0);
    tick();
    enq(1'b0, 13'h062, 32'h0, 2'b10, 1'b0);
    reset = 1'b1;
    #1;
    check("mrst_strobes", 32'({mi_load, mi_store}), 32'd0);
    check("mrst_addr", 32'(mi_address), 32'd0);
    check("mrst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    check("mrst_req_ready", 32'(cpu_req_ready), 32'd1);
    tick();
    reset = 1'b0;
    base_l = load_cnt;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      mi_output_valid = c[0];
      tick();
      if (cpu_resp_valid) seen = 1'b1;
    end
    mi_output_valid = 1'b0;
    check("mrst_no_stale", 32'(seen), 32'd0);
    check("mrst_fifo_empty", 32'(load_cnt - base_l), 32'd0);

`ifdef LSQ_TIMEOUT_EN
    // Watchdog: no completion, error after 8 WAIT cycles
    enq(1'b0, 13'h070, 32'h0, 2'b10, 1'b0);
    tick();
    check("to_strobe", 32'(mi_load), 32'd1);
    n = 0;
    while (!cpu_resp_valid && n < 50) begin
      tick();
      n++;
    end
    check("to_latency", 32'(n), 32'd9);
    check("to_err", 32'(cpu_resp_err), 32'd1);
    check("to_data", cpu_resp_data, 32'h0);
    mi_output_valid = 1'b1;
    mi_data_out = 32'h12345678;
    tick();
    check("to_late_hold", cpu_resp_data, 32'h0);
    cpu_resp_ready = 1'b1;
    tick();
    cpu_resp_ready = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (cpu_resp_valid) seen = 1'b1;
    end
    mi_output_valid = 1'b0;
    check("to_late_ignored", 32'(seen), 32'd0);
`else
    // Without the watchdog WAIT persists until completion arrives
    enq(1'b0, 13'h070, 32'h0, 2'b10, 1'b0);
    tick();
    check("nto_strobe", 32'(mi_load), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (cpu_resp_valid) seen = 1'b1;
    end
    check("nto_persist", 32'(seen), 32'd0);
    mi_output_valid = 1'b1;
    mi_data_out = 32'h0BADF00D;
    tick();
    mi_output_valid = 1'b0;
    check("nto_resp", cpu_resp_data, 32'h0BADF00D);
    check("nto_err", 32'(cpu_resp_err), 32'd0);
    cpu_resp_ready = 1'b1;
    tick();
    cpu_resp_ready = 1'b0;
`endif

    check("busy_viol_end", 32'(busy_viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
